// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer with one-shot/auto-reload modes and a masked IRQ.
// Defining TC_PRESCALE_EN adds a prescaler that slows the decrement to once every PRESCALE cycles.
module timer_counter #(
   parameter int PRESCALE = 4
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);
   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
   state_t state, state_n;
   logic [3:0] ctrl;
   logic [31:0] preset, count, count_n;
   logic irq_flag, flag_n, en_clr, tick, wr_ctrl, wr_preset;
   assign wr_ctrl = WE && Addr == 2'd0;
   assign wr_preset = WE && Addr == 2'd1;
`ifdef TC_PRESCALE_EN
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] pcnt;
   assign tick = pcnt == PW'(PRESCALE - 1);
   always_ff @(posedge clk)
      if (Reset || state == LOAD || (state == CNT && !ctrl[0])) pcnt <= '0;
      else if (state == CNT) pcnt <= tick ? '0 : pcnt + 1'b1;
`else
   assign tick = 1'b1;
`endif
   always_comb begin
      state_n = state;
      count_n = count;
      flag_n = irq_flag;
      en_clr = 1'b0;
      case (state)
         IDLE: state_n = ctrl[0] ? LOAD : IDLE;
         LOAD: begin
            count_n = preset;
            state_n = CNT;
         end
         CNT:
            if (!ctrl[0]) state_n = IDLE;
            else if (tick) begin
               count_n = count > 32'd1 ? count - 32'd1 : '0;
               flag_n = count <= 32'd1 ? 1'b1 : irq_flag;
               state_n = count <= 32'd1 ? INT : CNT;
            end
         INT: begin
            // auto-reload keeps Enable set and drops the flag; other modes stop and keep the flag
            flag_n = ctrl[2:1] == 2'd1 ? 1'b0 : irq_flag;
            en_clr = ctrl[2:1] != 2'd1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (Reset) begin
         state <= IDLE;
         ctrl <= '0;
         preset <= '0;
         count <= '0;
         irq_flag <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         irq_flag <= (wr_ctrl || wr_preset) ? 1'b0 : flag_n;
         if (wr_ctrl) ctrl <= Din[3:0];
         else if (en_clr) ctrl[0] <= 1'b0;
         if (wr_preset) preset <= Din;
      end
   assign Dout = Addr == 2'd0 ? {28'd0, ctrl} : Addr == 2'd1 ? preset : Addr == 2'd2 ? count : '0;
   assign IRQ = ctrl[3] & irq_flag;
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed and random bus traffic against a behavioural timer model.
module tb_timer_counter;
`ifdef TC_PRESCALE_EN
   localparam int PS = 4;
`else
   localparam int PS = 1;
`endif
   localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_DONE = 3;
   logic clk = 1'b0, Reset = 1'b1, WE = 1'b0, IRQ;
   logic [1:0] Addr = 2'd0;
   logic [31:0] Din = '0, Dout;
   int n_chk = 0, n_fail = 0;
   bit chk_on = 1'b0;
   logic [3:0] m_ctrl;
   logic [31:0] m_preset, m_count;
   logic m_flag;
   int m_stage, m_left;
   int hits[$];

   timer_counter #(.PRESCALE(4)) dut (.clk(clk), .Reset(Reset), .Addr(Addr), .WE(WE), .Din(Din),
      .Dout(Dout), .IRQ(IRQ));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [1:0] a);
      return a == 2'd0 ? {28'd0, m_ctrl} : a == 2'd1 ? m_preset : a == 2'd2 ? m_count : 32'd0;
   endfunction

   // Timer behaviour: a load step, a countdown that ticks every PS cycles, then one expiry step.
   task automatic model_edge(input logic r, input logic [1:0] a, input logic w, input logic [31:0] d);
      logic en, reload, stop;
      en = m_ctrl[0];
      reload = m_ctrl[2:1] == 2'b01;
      stop = 1'b0;
      if (r) begin
         m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_stage = S_IDLE; m_left = PS;
         return;
      end
      if (m_stage == S_IDLE) m_stage = en ? S_LOAD : S_IDLE;
      else if (m_stage == S_LOAD) begin
         m_count = m_preset; m_left = PS; m_stage = S_RUN;
      end else if (m_stage == S_RUN) begin
         if (!en) begin
            m_stage = S_IDLE; m_left = PS;
         end else if (m_left == 1) begin
            m_left = PS;
            if (m_count > 1) m_count = m_count - 1;
            else begin
               m_count = 0; m_flag = 1'b1; m_stage = S_DONE;
            end
         end else m_left = m_left - 1;
      end else begin
         if (reload) m_flag = 1'b0;
         else stop = 1'b1;
         m_stage = S_IDLE;
      end
      if (w && a == 2'd0) begin
         m_ctrl = d[3:0]; m_flag = 1'b0;
      end else if (stop) m_ctrl[0] = 1'b0;
      if (w && a == 2'd1) begin
         m_preset = d; m_flag = 1'b0;
      end
   endtask

   task automatic cyc(input logic r, input logic [1:0] a, input logic w, input logic [31:0] d);
      Reset = r; Addr = a; WE = w; Din = d;
      @(posedge clk);
      model_edge(r, a, w, d);
      #1;
   endtask

   always @(negedge clk)
      if (chk_on) begin
         check("dout", Dout, m_read(Addr));
         check("irq", {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_flag});
      end

   initial begin
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk_on = 1'b1;
      cyc(0, 0, 0, 0);
      check("rst_ctrl", Dout, 32'd0);
      check("rst_irq", {31'd0, IRQ}, 32'd0);
      cyc(0, 1, 0, 0);
      check("rst_preset", Dout, 32'd0);
      cyc(0, 2, 1, 5);
      cyc(0, 2, 0, 0);
      check("count_ro", Dout, 32'd0);
`ifndef TC_PRESCALE_EN
      cyc(0, 1, 1, 5);
      cyc(0, 0, 1, 9);
      for (int k = 1; k <= 7; k++) begin
         cyc(0, 2, 0, 0);
         if (k >= 2) check("oneshot_count", Dout, 32'(7 - k));
         check("oneshot_irq", {31'd0, IRQ}, {31'd0, k == 7});
      end
      cyc(0, 0, 0, 0);
      check("oneshot_ctrl", Dout, 32'h8);
      check("irq_held", {31'd0, IRQ}, 32'd1);
      cyc(0, 0, 1, 8);
      check("irq_cleared", {31'd0, IRQ}, 32'd0);
      for (int k = 0; k < 3; k++) cyc(0, 2, 0, 0);
      check("idle_count", Dout, 32'd0);
`endif
      cyc(0, 1, 1, PS == 1 ? 3 : 2);
      cyc(0, 0, 1, 32'hB);
      for (int k = 1; k <= 45; k++) begin
         cyc(0, 2, 0, 0);
         if (IRQ) hits.push_back(k);
      end
      check("reload_pulses", {31'd0, hits.size() >= 3}, 32'd1);
      if (hits.size() >= 1) check("reload_first", hits[0], PS == 1 ? 5 : 10);
      for (int i = 1; i < hits.size(); i++)
         check("reload_period", hits[i] - hits[i-1], PS == 1 ? 6 : 11);
      cyc(0, 0, 1, 8);
      for (int k = 0; k < 4; k++) cyc(0, 2, 0, 0);
`ifndef TC_PRESCALE_EN
      cyc(0, 1, 1, 5);
      cyc(0, 0, 1, 9);
      for (int k = 0; k < 3; k++) cyc(0, 2, 0, 0);
      cyc(0, 0, 1, 8);
      for (int k = 0; k < 4; k++) begin
         cyc(0, 2, 0, 0);
         check("freeze_count", Dout, 32'd3);
         check("freeze_irq", {31'd0, IRQ}, 32'd0);
      end
      cyc(0, 0, 1, 9);
      cyc(0, 2, 0, 0);
      cyc(0, 2, 0, 0);
      check("reload_preset", Dout, 32'd5);
      for (int k = 0; k < 8; k++) cyc(0, 2, 0, 0);
      cyc(0, 0, 1, 0);
`endif
      cyc(0, 1, 1, 0);
      cyc(0, 0, 1, 1);
      for (int k = 0; k < 3 + 2 * PS; k++) begin
         cyc(0, 2, 0, 0);
         check("masked_irq", {31'd0, IRQ}, 32'd0);
      end
      cyc(0, 0, 0, 0);
      check("masked_ctrl", Dout, 32'd0);
      cyc(0, 0, 1, 8);
      cyc(0, 2, 0, 0);
      check("masked_clr", {31'd0, IRQ}, 32'd0);
      cyc(0, 1, 1, 7);
      cyc(0, 0, 1, 9);
      for (int k = 0; k < 4; k++) cyc(0, 2, 0, 0);
      cyc(1, 0, 0, 0);
      check("midrst_ctrl", Dout, 32'd0);
      cyc(0, 1, 0, 0);
      check("midrst_preset", Dout, 32'd0);
      cyc(0, 2, 0, 0);
      check("midrst_count", Dout, 32'd0);
      check("midrst_irq", {31'd0, IRQ}, 32'd0);
      for (int i = 0; i < 4000; i++) begin
         logic r, w;
         logic [1:0] a;
         logic [31:0] d;
         r = $urandom_range(0, 299) == 0;
         w = $urandom_range(0, 7) == 0;
         a = 2'($urandom_range(0, 3));
         d = $urandom;
         if (a == 2'd1) d = $urandom_range(0, 6);
         if (a == 2'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         cyc(r, a, w, d);
      end
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
